// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit MIPS general-purpose register file for the decode stage.
// Two combinational read ports with same-cycle write-to-read bypass, one
// write port committing on posedge clk, $zero hardwired to 0, and a
// saturating count of committed writes.
// Optional debug read port guarded by the macro REG_FILE_DEBUG_EN.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic                  read_en_2,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
`ifdef REG_FILE_DEBUG_EN
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
`endif
  output logic [15:0]           write_count
);

  // The address decode assumes every encodable address maps to a register.
  if (REG_NUM != (1 << ADDR_WIDTH)) begin : g_bad_reg_num
    $error("reg_file: REG_NUM must equal 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] regs [REG_NUM];
  logic                  write_commit;

  // A write lands only when enabled and not aimed at $zero.
  assign write_commit = write_en && (write_addr != '0);

  // Register storage: async clear, single write per cycle.
  // NOTE: the whole array is reset here because reset must clear every
  // register immediately; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
    end else if (write_commit) begin
      regs[write_addr] <= write_data;
    end
  end

  // Committed-write counter, saturating at all ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_count <= '0;
    end else if (write_commit && (write_count != 16'hFFFF)) begin
      write_count <= write_count + 16'd1;
    end
  end

  // Read port 1: reset, enable, $zero, bypass, then storage.
  always_comb begin
    // NOTE: default first so no path leaves the output unassigned (no latch).
    read_data_1 = '0;
    if (!rst && read_en_1 && (read_addr_1 != '0)) begin
      if (write_en && (write_addr == read_addr_1)) begin
        read_data_1 = write_data;
      end else begin
        read_data_1 = regs[read_addr_1];
      end
    end
  end

  // Read port 2: same priority chain as port 1.
  always_comb begin
    read_data_2 = '0;
    if (!rst && read_en_2 && (read_addr_2 != '0)) begin
      if (write_en && (write_addr == read_addr_2)) begin
        read_data_2 = write_data;
      end else begin
        read_data_2 = regs[read_addr_2];
      end
    end
  end

`ifdef REG_FILE_DEBUG_EN
  // Debug peek: raw stored value, no bypass, no enable.
  always_comb begin
    dbg_data = '0;
    if (!rst && (dbg_addr != '0)) begin
      dbg_data = regs[dbg_addr];
    end
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Inputs change just after the falling edge; combinational outputs are
// sampled 1 ns later, well before the next rising edge.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en_1;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_1;
  logic        read_en_2;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_2;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [15:0] write_count;
`ifdef REG_FILE_DEBUG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .read_en_1   (read_en_1),
    .read_addr_1 (read_addr_1),
    .read_data_1 (read_data_1),
    .read_en_2   (read_en_2),
    .read_addr_2 (read_addr_2),
    .read_data_2 (read_data_2),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
`ifdef REG_FILE_DEBUG_EN
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
`endif
    .write_count (write_count)
  );

  // Present one write for the coming rising edge and let it commit.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic test_reset;
    do_write(5'd5, 32'hDEADBEEF);
    read_en_1   = 1'b1;
    read_addr_1 = 5'd5;
    #1;
    n_total++;
    if (read_data_1 !== 32'hDEADBEEF) $display("FAIL rst_pre_r5: got %h want %h", read_data_1, 32'hDEADBEEF);
    else n_pass++;
    n_total++;
    if (write_count !== 16'd1) $display("FAIL rst_pre_count: got %0d want 1", write_count);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (read_data_1 !== 32'h0) $display("FAIL rst_read_forced: got %h want 0", read_data_1);
    else n_pass++;
    n_total++;
    if (write_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", write_count);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (read_data_1 !== 32'h0) $display("FAIL rst_r5_cleared: got %h want 0", read_data_1);
    else n_pass++;
    // A write presented across an edge while reset is held must be dropped.
    @(negedge clk);
    rst        = 1'b1;
    write_en   = 1'b1;
    write_addr = 5'd6;
    write_data = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    write_en    = 1'b0;
    rst         = 1'b0;
    read_addr_1 = 5'd6;
    #1;
    n_total++;
    if (read_data_1 !== 32'h0) $display("FAIL rst_write_dropped: got %h want 0", read_data_1);
    else n_pass++;
    n_total++;
    if (write_count !== 16'd0) $display("FAIL rst_write_count: got %0d want 0", write_count);
    else n_pass++;
  endtask

  task automatic test_basic;
    @(negedge clk);
    write_en    = 1'b1;
    write_addr  = 5'd3;
    write_data  = 32'h00000011;
    read_en_1   = 1'b1;
    read_addr_1 = 5'd3;
    #1;
    n_total++;
    if (read_data_1 !== 32'h11) $display("FAIL basic_bypass: got %h want 11", read_data_1);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    #1;
    n_total++;
    if (read_data_1 !== 32'h11) $display("FAIL basic_stored: got %h want 11", read_data_1);
    else n_pass++;
    n_total++;
    if (write_count !== 16'd1) $display("FAIL basic_count: got %0d want 1", write_count);
    else n_pass++;
  endtask

  task automatic test_zero;
    @(negedge clk);
    write_en    = 1'b1;
    write_addr  = 5'd0;
    write_data  = 32'hFFFFFFFF;
    read_en_1   = 1'b1;
    read_addr_1 = 5'd0;
    read_en_2   = 1'b1;
    read_addr_2 = 5'd0;
    #1;
    n_total++;
    if (read_data_1 !== 32'h0) $display("FAIL zero_rd1_same: got %h want 0", read_data_1);
    else n_pass++;
    n_total++;
    if (read_data_2 !== 32'h0) $display("FAIL zero_rd2_same: got %h want 0", read_data_2);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    write_en = 1'b0;
    #1;
    n_total++;
    if (read_data_1 !== 32'h0) $display("FAIL zero_rd1_next: got %h want 0", read_data_1);
    else n_pass++;
    n_total++;
    if (read_data_2 !== 32'h0) $display("FAIL zero_rd2_next: got %h want 0", read_data_2);
    else n_pass++;
    n_total++;
    if (write_count !== 16'd1) $display("FAIL zero_count: got %0d want 1", write_count);
    else n_pass++;
  endtask

  task automatic test_dual_read;
    do_write(5'd1, 32'd7);
    do_write(5'd2, 32'd9);
    read_en_1   = 1'b1;
    read_addr_1 = 5'd1;
    read_en_2   = 1'b1;
    read_addr_2 = 5'd2;
    #1;
    n_total++;
    if (read_data_1 !== 32'd7) $display("FAIL dual_rd1: got %h want 7", read_data_1);
    else n_pass++;
    n_total++;
    if (read_data_2 !== 32'd9) $display("FAIL dual_rd2: got %h want 9", read_data_2);
    else n_pass++;
    read_en_2 = 1'b0;
    #1;
    n_total++;
    if (read_data_1 !== 32'd7) $display("FAIL gate_rd1: got %h want 7", read_data_1);
    else n_pass++;
    n_total++;
    if (read_data_2 !== 32'd0) $display("FAIL gate_rd2_off: got %h want 0", read_data_2);
    else n_pass++;
    read_en_1 = 1'b0;
    #1;
    n_total++;
    if (read_data_1 !== 32'd0) $display("FAIL gate_rd1_off: got %h want 0", read_data_1);
    else n_pass++;
    n_total++;
    if (write_count !== 16'd3) $display("FAIL dual_count: got %0d want 3", write_count);
    else n_pass++;
  endtask

  task automatic test_bypass_priority;
    do_write(5'd4, 32'd5);
    write_en    = 1'b1;
    write_addr  = 5'd4;
    write_data  = 32'd6;
    read_en_1   = 1'b1;
    read_addr_1 = 5'd4;
    read_en_2   = 1'b1;
    read_addr_2 = 5'd4;
    #1;
    n_total++;
    if (read_data_1 !== 32'd6) $display("FAIL byp_rd1_same: got %h want 6", read_data_1);
    else n_pass++;
    n_total++;
    if (read_data_2 !== 32'd6) $display("FAIL byp_rd2_same: got %h want 6", read_data_2);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    // Unrelated write to r7 while port 1 reads r4 and port 2 reads r7.
    write_addr  = 5'd7;
    write_data  = 32'h000000AA;
    read_addr_2 = 5'd7;
    #1;
    n_total++;
    if (read_data_1 !== 32'd6) $display("FAIL byp_rd1_stored: got %h want 6", read_data_1);
    else n_pass++;
    n_total++;
    if (read_data_2 !== 32'hAA) $display("FAIL byp_rd2_other: got %h want aa", read_data_2);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    write_en    = 1'b0;
    read_addr_2 = 5'd4;
    #1;
    n_total++;
    if (read_data_2 !== 32'd6) $display("FAIL byp_rd2_stored: got %h want 6", read_data_2);
    else n_pass++;
    n_total++;
    if (write_count !== 16'd6) $display("FAIL byp_count: got %0d want 6", write_count);
    else n_pass++;
`ifdef REG_FILE_DEBUG_EN
    dbg_addr = 5'd7;
    #1;
    n_total++;
    if (dbg_data !== 32'hAA) $display("FAIL dbg_r7: got %h want aa", dbg_data);
    else n_pass++;
`endif
  endtask

  task automatic test_saturation;
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      write_en   = 1'b1;
      write_addr = 5'd8;
      write_data = 32'(i);
      @(posedge clk);
    end
    @(negedge clk);
    write_en = 1'b0;
    #1;
    n_total++;
    if (write_count !== 16'hFFFE) $display("FAIL sat_fffe: got %h want fffe", write_count);
    else n_pass++;
    do_write(5'd8, 32'h0000FFFF);
    #1;
    n_total++;
    if (write_count !== 16'hFFFF) $display("FAIL sat_ffff: got %h want ffff", write_count);
    else n_pass++;
    do_write(5'd8, 32'h00010000);
    do_write(5'd8, 32'h00010001);
    #1;
    n_total++;
    if (write_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", write_count);
    else n_pass++;
    read_en_1   = 1'b1;
    read_addr_1 = 5'd8;
    #1;
    n_total++;
    if (read_data_1 !== 32'h00010001) $display("FAIL sat_r8: got %h want 00010001", read_data_1);
    else n_pass++;
  endtask

  initial begin
    rst         = 1'b1;
    read_en_1   = 1'b0;
    read_addr_1 = '0;
    read_en_2   = 1'b0;
    read_addr_2 = '0;
    write_en    = 1'b0;
    write_addr  = '0;
    write_data  = '0;
`ifdef REG_FILE_DEBUG_EN
    dbg_addr    = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_dual_read();
    test_bypass_priority();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
